// File: rtl/rom_16_byte.sv
// Program store for the TD4 CPU: sixteen 8-bit registers read combinationally
// as {opcode, immediate}, reloadable through a synchronous write port.
module rom_16_byte (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ADDRESS,
    output logic [3:0] ROM_DATA,
    output logic [3:0] OP_CODE,
    input  logic       WR_EN,
    input  logic [3:0] WR_ADDRESS,
    input  logic [7:0] WR_DATA
);

    logic [7:0] word_q [16];
    logic [7:0] word_d [16];

    // Boot program restored on every RESET assertion.
    function automatic logic [7:0] default_word(input logic [3:0] a);
        logic [7:0] w;
        case (a)
            4'd0:    w = 8'hB7;
            4'd1:    w = 8'h01;
            4'd2:    w = 8'hE1;
            4'd3:    w = 8'h01;
            4'd4:    w = 8'hE3;
            4'd5:    w = 8'hB6;
            4'd6:    w = 8'h01;
            4'd7:    w = 8'hE6;
            4'd8:    w = 8'h01;
            4'd9:    w = 8'hE8;
            4'd10:   w = 8'hB0;
            4'd11:   w = 8'hB4;
            4'd12:   w = 8'h01;
            4'd13:   w = 8'hEA;
            4'd14:   w = 8'hB8;
            default: w = 8'hFF;
        endcase
        return w;
    endfunction

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            word_d[i] = word_q[i];
        end
        if (WR_EN) begin
            word_d[WR_ADDRESS] = WR_DATA;
        end
    end

    // Reset is checked first, so a write in a reset cycle is dropped.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) begin
                word_q[i] <= default_word(4'(i));
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    // No bypass: a same-address write shows up only after the capturing edge.
    assign {OP_CODE, ROM_DATA} = word_q[ADDRESS];

endmodule

// File: tb/tb_rom_16_byte.sv
// Self-checking bench for rom_16_byte: a reference memory feeds an expected
// queue at read time; DUT outputs are popped and compared once settled.
module tb_rom_16_byte;

    logic       CLK;
    logic       RESET;
    logic [3:0] ADDRESS;
    logic [3:0] ROM_DATA;
    logic [3:0] OP_CODE;
    logic       WR_EN;
    logic [3:0] WR_ADDRESS;
    logic [7:0] WR_DATA;

    logic [7:0] exp_q[$];
    logic [7:0] model_mem [16];
    logic [7:0] dflt [16];
    int         n_tests;
    int         n_fail;

    rom_16_byte dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADDRESS    (ADDRESS),
        .ROM_DATA   (ROM_DATA),
        .OP_CODE    (OP_CODE),
        .WR_EN      (WR_EN),
        .WR_ADDRESS (WR_ADDRESS),
        .WR_DATA    (WR_DATA)
    );

    // Clock / reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_default_model();
        for (int i = 0; i < 16; i++) model_mem[i] = dflt[i];
    endtask

    // Driver: present an address and queue the value the model says it holds.
    task automatic drive_read(input logic [3:0] a);
        ADDRESS = a;
        exp_q.push_back(model_mem[a]);
    endtask

    // Scoreboard: pop the oldest expectation and compare with the DUT output.
    task automatic compare_read(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_noexp"}, {OP_CODE, ROM_DATA}, 8'hxx);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, {OP_CODE, ROM_DATA}, e);
        end
    endtask

    task automatic read_check(input logic [3:0] a, input string tag);
        drive_read(a);
        #1;
        compare_read(tag);
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        WR_EN = 1'b1;
        WR_ADDRESS = a;
        WR_DATA = d;
        @(posedge CLK);
        if (!RESET) model_mem[a] = d;
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    initial begin
        dflt = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                 8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        n_tests = 0;
        n_fail = 0;
        RESET = 1'b0;
        ADDRESS = 4'd0;
        WR_EN = 1'b0;
        WR_ADDRESS = 4'd0;
        WR_DATA = 8'h00;

        // Reset contents appear combinationally, before any clock edge.
        #2;
        RESET = 1'b1;
        load_default_model();
        read_check(4'd15, "reset_async_15");
        read_check(4'd0, "reset_async_0");
        @(negedge CLK);
        RESET = 1'b0;

        // Reset then scan, one address per 1000 ns.
        for (int i = 0; i < 16; i++) begin
            drive_read(4'(i));
            #1000;
            compare_read($sformatf("scan_%0d", i));
        end

        // Single write
        write_word(4'd3, 8'h5C);
        read_check(4'd3, "write_3");
        read_check(4'd2, "neighbour_2");
        read_check(4'd4, "neighbour_4");

        // WR_EN low changes nothing
        @(negedge CLK);
        WR_EN = 1'b0;
        WR_ADDRESS = 4'd7;
        WR_DATA = 8'h00;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        read_check(4'd7, "wren_low_7");

        // Read during write: old value before the edge, new value after
        @(negedge CLK);
        WR_EN = 1'b1;
        WR_ADDRESS = 4'd9;
        WR_DATA = 8'hA4;
        read_check(4'd9, "rdw_before");
        @(posedge CLK);
        model_mem[9] = 8'hA4;
        #1;
        read_check(4'd9, "rdw_after");
        @(negedge CLK);
        WR_EN = 1'b0;

        // Reset has priority over a simultaneous write
        write_word(4'd0, 8'h3D);
        read_check(4'd0, "pre_reset_0");
        @(negedge CLK);
        RESET = 1'b1;
        WR_EN = 1'b1;
        WR_ADDRESS = 4'd0;
        WR_DATA = 8'h12;
        load_default_model();
        @(posedge CLK);
        @(negedge CLK);
        WR_EN = 1'b0;
        RESET = 1'b0;
        read_check(4'd0, "reset_over_write_0");
        read_check(4'd9, "reset_restores_9");

        // Writes work again once reset is released
        write_word(4'd0, 8'h12);
        read_check(4'd0, "post_reset_write_0");

        // Random writes against the model
        for (int k = 0; k < 20; k++) begin
            write_word(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)));
        end
        for (int i = 0; i < 16; i++) begin
            read_check(4'(i), $sformatf("rand_%0d", i));
        end

        // Reset mid-operation: clear everything, then assert between edges
        for (int i = 0; i < 16; i++) write_word(4'(i), 8'h00);
        read_check(4'd15, "cleared_15");
        read_check(4'd5, "cleared_5");
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        load_default_model();
        for (int i = 0; i < 16; i++) begin
            read_check(4'(i), $sformatf("midreset_%0d", i));
        end
        @(negedge CLK);
        RESET = 1'b0;
        read_check(4'd15, "after_midreset_15");

        check_eq("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
